// File: rtl/truth_table_scanner_pkg.sv
// Shared types and sizes for the truth-table scanner and its settle timer.
package truth_scan_pkg;

  localparam int NUM_VEC = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic b;
    logic a;
    logic c;
  } abc_t;

  // Vector index maps onto the function inputs as {b,a,c} = idx.
  function automatic abc_t idx_to_vec(input logic [IDX_W-1:0] idx);
    abc_t v;
    v.b = idx[2];
    v.a = idx[1];
    v.c = idx[0];
    return v;
  endfunction

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Down-counter that holds each vector for a programmable number of extra cycles.
module scan_settle_timer
  import truth_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Sequencer that walks all eight inputs of a 3-input function, captures y and grades it.
module truth_table_scanner
  import truth_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [NUM_VEC-1:0] expected,
  output logic               dut_a,
  output logic               dut_b,
  output logic               dut_c,
  input  logic               dut_y,
  output logic               busy,
  output logic               done,
  output logic [NUM_VEC-1:0] table_out,
  output logic               pass,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [IDX_W-1:0]   first_bad
);

  scan_state_e        state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [NUM_VEC-1:0] exp_q;
  abc_t               vec;
  logic               accept;
  logic               last;
  logic               load;
  logic               expired;

  assign accept = (state == IDLE) && start && !abort;
  assign last   = (idx == IDX_W'(NUM_VEC - 1));

  scan_settle_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .value   (CNT_W'(SETTLE_CYCLES)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRIVE;
      DRIVE:   if (abort) state_nxt = IDLE;
               else if (expired) state_nxt = SAMPLE;
      SAMPLE:  if (abort) state_nxt = IDLE;
               else if (last) state_nxt = DONE;
               else state_nxt = DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The timer is reloaded whenever a fresh vector is about to be driven.
  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    case (state)
      IDLE:    load = accept;
      DRIVE:   busy = 1'b1;
      SAMPLE:  begin
        busy = 1'b1;
        load = !abort && !last;
      end
      default: begin
        busy = 1'b0;
        load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      exp_q        <= '0;
      vec          <= '0;
      table_out    <= '0;
      mismatch_cnt <= '0;
      first_bad    <= '0;
      pass         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            exp_q        <= expected;
            table_out    <= '0;
            mismatch_cnt <= '0;
            first_bad    <= '0;
            idx          <= '0;
            vec          <= idx_to_vec('0);
          end
        end
        DRIVE, SAMPLE: begin
          if (abort) begin
            vec          <= '0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            first_bad    <= '0;
            pass         <= 1'b0;
          end else if (state == SAMPLE) begin
            table_out[idx] <= dut_y;
            if (dut_y != exp_q[idx]) begin
              mismatch_cnt <= mismatch_cnt + CNT_W'(1);
              if (mismatch_cnt == '0) first_bad <= idx;
            end
            if (!last) begin
              idx <= idx + IDX_W'(1);
              vec <= idx_to_vec(idx + IDX_W'(1));
            end
          end
        end
        DONE: begin
          vec <= '0;
          if (abort) begin
            table_out    <= '0;
            mismatch_cnt <= '0;
            first_bad    <= '0;
            pass         <= 1'b0;
          end else begin
            done <= 1'b1;
            pass <= (mismatch_cnt == '0);
          end
        end
        default: vec <= '0;
      endcase
    end
  end

  assign dut_a = vec.a;
  assign dut_b = vec.b;
  assign dut_c = vec.c;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized bench for truth_table_scanner: two instances (settle 1 and 0) graded by a table-level model.
module tb_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [7:0] expected;
  logic [7:0] ft;

  logic       a1, b1, c1, y1, busy1, done1, pass1;
  logic [7:0] tab1;
  logic [3:0] mm1;
  logic [2:0] fb1;
  logic       a0, b0, c0, y0, busy0, done0, pass0;
  logic [7:0] tab0;
  logic [3:0] mm0;
  logic [2:0] fb0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // The function under test is a lookup of {b,a,c} into ft.
  assign y1 = ft[{b1, a1, c1}];
  assign y0 = ft[{b0, a0, c0}];

  truth_table_scanner #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_y(y1), .busy(busy1), .done(done1),
    .table_out(tab1), .pass(pass1), .mismatch_cnt(mm1), .first_bad(fb1)
  );

  truth_table_scanner #(.SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_y(y0), .busy(busy0), .done(done0),
    .table_out(tab0), .pass(pass0), .mismatch_cnt(mm0), .first_bad(fb0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  function automatic int popcnt(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, " s1 outs"}, {busy1, done1, pass1, a1, b1, c1, tab1, mm1, fb1}, '0);
    check({tag, " s0 outs"}, {busy0, done0, pass0, a0, b0, c0, tab0, mm0, fb0}, '0);
  endtask

  // One full scan; the model grades the function table against the value latched at start.
  task automatic run_scan(input string tag, input logic [7:0] f, input logic [7:0] exp_v,
                          input bit restart_mid, input bit change_exp);
    int k1 = -1, k0 = -1, n1 = 0, n0 = 0;
    int diff;
    @(negedge clk);
    ft = f;
    expected = exp_v;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5 && restart_mid) start = 1'b1;
      if (k == 3 && change_exp) expected = ~exp_v;
      @(posedge clk);
      #1 start = 1'b0;
      if (k == 1) check({tag, " busy"}, {busy1, busy0}, 2'b11);
      if (done1) begin n1++; if (k1 < 0) k1 = k; end
      if (done0) begin n0++; if (k0 < 0) k0 = k; end
    end
    diff = popcnt(f ^ exp_v);
    check({tag, " s1 table"}, tab1, f);
    check({tag, " s0 table"}, tab0, f);
    check({tag, " s1 pass"}, pass1, (diff == 0));
    check({tag, " s0 pass"}, pass0, (diff == 0));
    check({tag, " s1 mism"}, mm1, diff);
    check({tag, " s0 mism"}, mm0, diff);
    check({tag, " s1 first"}, fb1, lowest(f ^ exp_v));
    check({tag, " s0 first"}, fb0, lowest(f ^ exp_v));
    check({tag, " s1 done cyc"}, k1, 8 * (1 + 2) + 1);
    check({tag, " s0 done cyc"}, k0, 8 * (0 + 2) + 1);
    check({tag, " done cnt"}, {n1[7:0], n0[7:0]}, 16'h0101);
    check({tag, " idle vec"}, {a1, b1, c1, a0, b0, c0, busy1, busy0}, '0);
  endtask

  initial begin
    logic [7:0] f, e;
    int nd;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    expected = 8'h00;
    ft = 8'h18;
    #1 check_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_scan("golden", 8'h18, 8'h18, 1'b0, 1'b0);
    run_scan("one_bad", 8'h18, 8'h19, 1'b0, 1'b0);
    run_scan("all_bad", 8'h18, 8'hE7, 1'b0, 1'b0);
    run_scan("restart", 8'h18, 8'h18, 1'b1, 1'b0);
    run_scan("exp_chg", 8'h5A, 8'h5B, 1'b0, 1'b1);

    // abort together with start in IDLE must not begin a scan
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 check("abort_start busy", {busy1, busy0}, 2'b00);
    start = 1'b0;
    abort = 1'b0;

    // abort while the settle-1 instance drives idx 3
    @(negedge clk);
    ft = 8'h18;
    expected = 8'h18;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("abort idx", {b1, a1, c1}, 3'd3);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_zero("abort");
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1 if (done1 || done0) nd++;
    end
    check("abort no done", nd, 0);

    // asynchronous reset during SAMPLE of idx 5 on the settle-1 instance
    @(negedge clk);
    ft = 8'h3C;
    expected = 8'h18;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (17) @(posedge clk);
    #1 check("pre-rst idx", {b1, a1, c1}, 3'd5);
    rst_n = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk) rst_n = 1'b1;
    run_scan("post_rst", 8'h18, 8'h18, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      f = 8'($urandom);
      e = ($urandom_range(0, 2) == 0) ? f : 8'($urandom);
      run_scan($sformatf("rnd%0d", i), f, e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
